// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared motion estimation geometry and widths
package me_pkg;

    localparam int DATA_W  = 8;
    localparam int R_DIM   = 16;
    localparam int S_DIM   = 31;
    localparam int R_DEPTH = R_DIM * R_DIM;
    localparam int S_DEPTH = S_DIM * S_DIM;
    localparam int R_AW    = $clog2(R_DEPTH);
    localparam int S_AW    = $clog2(S_DEPTH);
    localparam int LOAD_AW = S_AW;

    typedef enum logic {
        SEL_REF  = 1'b0,
        SEL_SRCH = 1'b1
    } load_sel_e;

endpackage

// File: rtl/me_mem_bank.sv
// rtl/me_mem_bank.sv - single-write multi-read pixel bank with registered reads
module me_mem_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH),
    parameter int N_RD   = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [N_RD-1:0][AW-1:0]        raddr,
    output logic [N_RD-1:0][DATA_W-1:0]    rdata
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DATA_W-1:0]             mem_q [DEPTH];
    logic                          wr_en;
    logic [N_RD-1:0][DATA_W-1:0]   rdata_d;
    logic [N_RD-1:0][DATA_W-1:0]   rdata_q;

    // Reads see the array before this edge's write lands, giving old data on a collision.
    always_comb begin
        wr_en = we && reset_n && ({1'b0, waddr} < DEPTH_L);
        for (int p = 0; p < N_RD; p++) begin
            rdata_d[p] = '0;
            if ({1'b0, raddr[p]} < DEPTH_L) begin
                rdata_d[p] = mem_q[raddr[p]];
            end
        end
    end

    // Contents are intentionally not reset so they survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/motion_estimation_memory.sv
// rtl/motion_estimation_memory.sv - reference and search pixel memories for the motion estimator
module motion_estimation_memory
    import me_pkg::*;
#(
    parameter int DATA_W = me_pkg::DATA_W,
    parameter int R_DIM  = me_pkg::R_DIM,
    parameter int S_DIM  = me_pkg::S_DIM
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load_en,
    input  logic                 load_sel,
    input  logic [LOAD_AW-1:0]   load_addr,
    input  logic [DATA_W-1:0]    load_data,
    input  logic [R_AW-1:0]      AddressR,
    input  logic [S_AW-1:0]      AddressS1,
    input  logic [S_AW-1:0]      AddressS2,
    output logic [DATA_W-1:0]    R,
    output logic [DATA_W-1:0]    S1,
    output logic [DATA_W-1:0]    S2
);

    logic                       ref_we;
    logic                       srch_we;
    logic [1:0][DATA_W-1:0]     srch_rdata;

    always_comb begin
        ref_we  = load_en && (load_sel_e'(load_sel) == SEL_REF);
        srch_we = load_en && (load_sel_e'(load_sel) == SEL_SRCH);
    end

    // Reference writes drop the upper load address bits.
    me_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (R_DIM * R_DIM),
        .AW     (R_AW),
        .N_RD   (1)
    ) u_ref_bank (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (ref_we),
        .waddr   (load_addr[R_AW-1:0]),
        .wdata   (load_data),
        .raddr   (AddressR),
        .rdata   (R)
    );

    me_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (S_DIM * S_DIM),
        .AW     (S_AW),
        .N_RD   (2)
    ) u_srch_bank (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (srch_we),
        .waddr   (load_addr),
        .wdata   (load_data),
        .raddr   ({AddressS2, AddressS1}),
        .rdata   (srch_rdata)
    );

    assign S1 = srch_rdata[0];
    assign S2 = srch_rdata[1];

endmodule

// File: tb/tb_motion_estimation_memory.sv
// tb/tb_motion_estimation_memory.sv - self-checking bench for motion_estimation_memory
module tb_motion_estimation_memory;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       load_en;
    logic       load_sel;
    logic [9:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic [7:0] R;
    logic [7:0] S1;
    logic [7:0] S2;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ref_m  [256];
    logic [7:0]  srch_m [961];
    logic [23:0] sb_q [$];

    typedef struct {
        logic       le;
        logic       ls;
        logic [9:0] la;
        logic [7:0] ld;
        logic [7:0] ar;
        logic [9:0] as1;
        logic [9:0] as2;
        logic [7:0] er;
        logic [7:0] es1;
        logic [7:0] es2;
    } vec_t;

    vec_t tbl [15];

    motion_estimation_memory dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .S1        (S1),
        .S2        (S2)
    );

    always #5 clock = ~clock;

    task automatic check3(input string nm, input logic [7:0] er, input logic [7:0] es1,
                          input logic [7:0] es2);
        checks++;
        if (R !== er || S1 !== es1 || S2 !== es2) begin
            errors++;
            $display("FAIL %s: R/S1/S2 got %h %h %h expected %h %h %h", nm, R, S1, S2, er, es1, es2);
        end
    endtask

    function automatic logic [7:0] srch_rd(input logic [9:0] a);
        return (a < 10'd961) ? srch_m[a] : 8'h00;
    endfunction

    task automatic model_write(input logic le, input logic ls, input logic [9:0] la,
                               input logic [7:0] ld);
        if (le) begin
            if (!ls) ref_m[la[7:0]] = ld;
            else if (la < 10'd961) srch_m[la] = ld;
        end
    endtask

    // Called at a falling edge; drives one cycle and checks outputs at the next falling edge.
    task automatic do_cycle(input string nm, input logic chk, input logic le, input logic ls,
                            input logic [9:0] la, input logic [7:0] ld, input logic [7:0] ar,
                            input logic [9:0] as1, input logic [9:0] as2, input logic [7:0] er,
                            input logic [7:0] es1, input logic [7:0] es2);
        logic [23:0] exp_v;
        load_en = le; load_sel = ls; load_addr = la; load_data = ld;
        AddressR = ar; AddressS1 = as1; AddressS2 = as2;
        if (chk) sb_q.push_back({er, es1, es2});
        @(negedge clock);
        if (chk) begin
            exp_v = sb_q.pop_front();
            check3(nm, exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
    endtask

    task automatic model_cycle(input string nm, input logic le, input logic ls,
                               input logic [9:0] la, input logic [7:0] ld, input logic [7:0] ar,
                               input logic [9:0] as1, input logic [9:0] as2);
        logic [7:0] er, es1, es2;
        er = ref_m[ar]; es1 = srch_rd(as1); es2 = srch_rd(as2);
        do_cycle(nm, 1'b1, le, ls, la, ld, ar, as1, as2, er, es1, es2);
        model_write(le, ls, la, ld);
    endtask

    initial begin
        reset_n = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
        AddressR = 8'd5; AddressS1 = '0; AddressS2 = '0;

        repeat (3) @(negedge clock);
        check3("reset_hold", 8'h00, 8'h00, 8'h00);
        reset_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            do_cycle("fill_r", 1'b0, 1'b1, 1'b0, 10'(i), 8'(i) ^ 8'h5A, 8'd0, 10'd0, 10'd0, 8'h0, 8'h0, 8'h0);
            model_write(1'b1, 1'b0, 10'(i), 8'(i) ^ 8'h5A);
        end
        for (int i = 0; i < 961; i++) begin
            do_cycle("fill_s", 1'b0, 1'b1, 1'b1, 10'(i), 8'(i * 7 + 3), 8'd0, 10'd0, 10'd0, 8'h0, 8'h0, 8'h0);
            model_write(1'b1, 1'b1, 10'(i), 8'(i * 7 + 3));
        end
        load_en = 1'b0;

        // Reset with a write pending: outputs zero and the write is blocked.
        reset_n = 1'b0; load_en = 1'b1; load_sel = 1'b0; load_addr = 10'd5; load_data = 8'h99;
        AddressR = 8'd5;
        #1 check3("reset_async", 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clock);
        check3("reset_held", 8'h00, 8'h00, 8'h00);
        reset_n = 1'b1;
        do_cycle("reset_release", 1'b1, 1'b0, 1'b0, 10'd0, 8'h0, 8'd5, 10'd1023, 10'd1023, 8'h5F, 8'h00, 8'h00);

        tbl[0]  = '{1'b1, 1'b0, 10'h00A, 8'h3C, 8'd0,  10'd1023, 10'd1023, 8'h5A, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 10'd960, 8'hF1, 8'h0A, 10'd1023, 10'd1023, 8'h3C, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 10'd0,   8'h00, 8'h0A, 10'd960,  10'd1023, 8'h3C, 8'hF1, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 10'd31,  8'h21, 8'd0,  10'd1023, 10'd1023, 8'h5A, 8'h00, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 10'd62,  8'h42, 8'd0,  10'd1023, 10'd1023, 8'h5A, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 10'd100, 8'h64, 8'd0,  10'd1023, 10'd1023, 8'h5A, 8'h00, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 10'd0,   8'h00, 8'd0,  10'd31,   10'd62,   8'h5A, 8'h21, 8'h42};
        tbl[7]  = '{1'b0, 1'b0, 10'd0,   8'h00, 8'd0,  10'd100,  10'd100,  8'h5A, 8'h64, 8'h64};
        tbl[8]  = '{1'b1, 1'b1, 10'd1000, 8'hAA, 8'd0, 10'd1023, 10'd1000, 8'h5A, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 10'd0,   8'h00, 8'd0,  10'd1000, 10'd1000, 8'h5A, 8'h00, 8'h00};
        tbl[10] = '{1'b1, 1'b1, 10'd7,   8'h11, 8'd0,  10'd1023, 10'd1023, 8'h5A, 8'h00, 8'h00};
        tbl[11] = '{1'b1, 1'b1, 10'd7,   8'h55, 8'd0,  10'd7,    10'd1023, 8'h5A, 8'h11, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 10'd0,   8'h00, 8'd0,  10'd7,    10'd1023, 8'h5A, 8'h55, 8'h00};
        tbl[13] = '{1'b1, 1'b0, 10'h30A, 8'hC3, 8'h0A, 10'd1023, 10'd1023, 8'h3C, 8'h00, 8'h00};
        tbl[14] = '{1'b0, 1'b0, 10'd0,   8'h00, 8'h0A, 10'd960,  10'd31,   8'hC3, 8'hF1, 8'h21};

        for (int i = 0; i < 15; i++) begin
            do_cycle($sformatf("vec%0d", i), 1'b1, tbl[i].le, tbl[i].ls, tbl[i].la, tbl[i].ld,
                     tbl[i].ar, tbl[i].as1, tbl[i].as2, tbl[i].er, tbl[i].es1, tbl[i].es2);
            model_write(tbl[i].le, tbl[i].ls, tbl[i].la, tbl[i].ld);
        end

        // Streaming traffic with a mid-operation reset pulse.
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                load_en = 1'b0;
                #2 reset_n = 1'b0;
                #1 check3("midreset_drop", 8'h00, 8'h00, 8'h00);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    check3($sformatf("midreset_hold%0d", k), 8'h00, 8'h00, 8'h00);
                end
                reset_n = 1'b1;
            end
            model_cycle($sformatf("stream%0d", i), ($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)),
                        10'($urandom_range(1023, 0)), 8'($urandom), 8'($urandom_range(255, 0)),
                        10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)));
        end

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/motion_estimation_memory.md
MOTION_ESTIMATION_MEMORY -- requirements
Module: motion_estimation_memory

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits.
REQ-002 Parameter R_DIM, default 16: reference block edge, giving R_DEPTH = 256 pixels.
REQ-003 Parameter S_DIM, default 31: search window edge, giving S_DEPTH = 961 pixels.
REQ-004 Port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port load_en, input, 1 bit: write strobe for contents loading.
REQ-007 Port load_sel, input, 1 bit: 0 = reference memory, 1 = search memory.
REQ-008 Port load_addr, input, 10 bits: linear write address.
REQ-009 Port load_data, input, DATA_W bits: write data.
REQ-010 Port AddressR, input, 8 bits: reference read address, row*16+col.
REQ-011 Port AddressS1, input, 10 bits: search read port 1 address, row*31+col.
REQ-012 Port AddressS2, input, 10 bits: search read port 2 address, row*31+col.
REQ-013 Port R, output, DATA_W bits: reference pixel.
REQ-014 Port S1, output, DATA_W bits: search pixel for port 1.
REQ-015 Port S2, output, DATA_W bits: search pixel for port 2.

Function
REQ-016 The block SHALL hold a 256-entry reference memory and a 961-entry search memory, each DATA_W wide.
REQ-017 R, S1 and S2 SHALL be registered with one-cycle read latency: the address sampled at edge N appears on the output after edge N.
REQ-018 The three read ports SHALL operate independently and concurrently every cycle, with no enable.
REQ-019 AddressS1 and AddressS2 SHALL be permitted to be equal; both outputs then carry the same word.
REQ-020 A search read address of 961..1023 SHALL return 0.
REQ-021 When load_en = 1, load_data SHALL be written at the edge to the memory selected by load_sel, at load_addr.
REQ-022 For reference writes, only load_addr[7:0] SHALL be used; bits [9:8] are ignored.
REQ-023 A search write to an address of 961..1023 SHALL be ignored.
REQ-024 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-025 Memory contents SHALL persist until overwritten; there is no state machine and no handshake.

Reset
REQ-026 While reset_n = 0, R, S1 and S2 SHALL be 0 asynchronously.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Writes SHALL be blocked while reset_n = 0.
REQ-029 Reads SHALL resume on the first rising edge after reset_n deasserts.
REQ-030 Asserting reset mid-operation SHALL zero the outputs only; contents loaded before reset SHALL remain readable afterwards.

Structure
REQ-031 DATA_W, R_DIM, S_DIM, R_DEPTH, S_DEPTH and the address widths SHALL live in a shared package, me_pkg, also used by the motion estimator core.
REQ-032 A single sub-module, me_mem_bank, SHALL be used.
REQ-033 me_mem_bank SHALL be parameterized by depth and number of read ports, with one write port and registered reads with out-of-range zeroing.
REQ-034 me_mem_bank SHALL be instantiated once for the reference memory (1 read port) and once for the search memory (2 read ports).

Verification
REQ-035 Reset then read: hold reset_n = 0 with AddressR = 5 -> R = S1 = S2 = 0; after release, R = the loaded value one edge later.
REQ-036 Load and read back: load reference addr 0x0A = 0x3C and search addr 960 = 0xF1; read AddressR = 0x0A and AddressS1 = 960 -> R = 0x3C, S1 = 0xF1 exactly one cycle later.
REQ-037 Dual port: AddressS1 = 31 (row 1, col 0) and AddressS2 = 62 (row 2, col 0) in the same cycle -> S1 and S2 carry the distinct loaded values; with both addresses set to 100 -> identical outputs.
REQ-038 Out of range: search write to addr 1000 with data 0xAA -> ignored; reading AddressS2 = 1000 -> S2 = 0.
REQ-039 Read-during-write: write search addr 7 = 0x55 (old value 0x11) while AddressS1 = 7 -> S1 = 0x11, then 0x55 on the following cycle.
REQ-040 Mid-operation reset: pulse reset_n low for 3 cycles during streaming reads -> outputs drop to 0 immediately; contents unchanged after release.
